// File: rtl/sqrt_pkg.sv
// ============================================================================
// sqrt_pkg : shared widths, FSM encodings and result constants for sqrt.
// Rev 1.0
// ============================================================================
`default_nettype none

package sqrt_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int RAD_W    = 48;
  localparam int REM_W    = 26;
  localparam int ROOT_W   = 25;

  // Shared with the downstream result selector.
  localparam logic [31:0] QNAN_VAL = 32'h7FC0_0000;
  localparam logic [31:0] ONE_VAL  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/checkspecial.sv
// ============================================================================
// checkspecial : Inf / NaN / zero flags from exponent and mantissa fields.
// Rev 1.0
// ============================================================================
`default_nettype none

module checkspecial
  import sqrt_pkg::*;
(
  input  logic [EXP_W-1:0] exp_f,
  input  logic [MAN_W-1:0] man_f,
  output logic             is_inf,
  output logic             is_nan,
  output logic             is_zero
);

  logic w_exp_ones;
  logic w_exp_zero;
  logic w_man_zero;

  assign w_exp_ones = &exp_f;
  assign w_exp_zero = ~|exp_f;
  assign w_man_zero = ~|man_f;

  assign is_inf  = w_exp_ones &  w_man_zero;
  assign is_nan  = w_exp_ones & ~w_man_zero;
  assign is_zero = w_exp_zero &  w_man_zero;

endmodule

`default_nettype wire

// File: rtl/sqrt_iter_core.sv
// ============================================================================
// sqrt_iter_core : restoring digit-by-digit FP32 square root, one bit/clock.
// Optional round-to-nearest-even via macro SQRT_ROUND_NEAREST_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sqrt_iter_core
  import sqrt_pkg::*;
#(
  parameter int ITER_BITS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  output logic [31:0] ansS,
  output logic        busy,
  output logic        done
);

`ifdef SQRT_ROUND_NEAREST_EN
  localparam int LAST_CNT = ITER_BITS;
`else
  localparam int LAST_CNT = ITER_BITS - 1;
`endif
  localparam int CNT_W = $clog2(ITER_BITS + 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [RAD_W-1:0]   r_rad;
  logic [REM_W-1:0]   r_rem;
  logic [ROOT_W-1:0]  r_root;
  logic [EXP_W-1:0]   r_exp;
  logic               r_special;
  logic [31:0]        r_ans;
  logic               r_busy;
  logic               r_done;

  logic [EXP_W-1:0]   w_exp_f;
  logic [MAN_W-1:0]   w_man_f;
  logic               w_inf, w_nan, w_zero, w_denorm, w_special;
  logic               w_accept;
  logic [RAD_W-1:0]   w_rad_init;
  logic [EXP_W:0]     w_exp_sum;
  logic [REM_W-1:0]   w_rem_sh, w_trial, w_rem_nx;
  logic               w_ge;
  logic [EXP_W-1:0]   w_exp_out;
  logic [MAN_W-1:0]   w_man_out;
  logic               w_unused_bits;

  assign w_exp_f = A[30:23];
  assign w_man_f = A[22:0];

  checkspecial u_checkspecial (
    .exp_f   (w_exp_f),
    .man_f   (w_man_f),
    .is_inf  (w_inf),
    .is_nan  (w_nan),
    .is_zero (w_zero)
  );

  assign w_denorm  = (w_exp_f == '0) && (w_man_f != '0);
  assign w_special = w_inf | w_nan | w_zero | w_denorm;

  // FIN is the hand-off cycle, so a new request may be taken there too.
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_FIN));

  // Odd biased exponent keeps 1.M as is; even folds a factor of 2 into it.
  assign w_rad_init = w_exp_f[0] ? {2'b01, w_man_f, 23'b0} : {1'b1, w_man_f, 24'b0};
  assign w_exp_sum  = {1'b0, w_exp_f} + (w_exp_f[0] ? 9'(EXP_BIAS) : 9'(EXP_BIAS - 1));

  assign w_rem_sh = {r_rem[REM_W-3:0], r_rad[RAD_W-1 -: 2]};
  assign w_trial  = {r_root[REM_W-3:0], 2'b01};
  assign w_ge     = (w_rem_sh >= w_trial);
  assign w_rem_nx = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;

`ifdef SQRT_ROUND_NEAREST_EN
  logic         w_round_up;
  logic [MAN_W:0] w_man_sum;
  assign w_round_up    = r_root[0] & ((|r_rem) | r_root[1]);
  assign w_man_sum     = {1'b0, r_root[MAN_W:1]} + (MAN_W+1)'(w_round_up);
  assign w_man_out     = w_man_sum[MAN_W] ? '0 : w_man_sum[MAN_W-1:0];
  assign w_exp_out     = r_exp + EXP_W'(w_man_sum[MAN_W]);
  assign w_unused_bits = r_root[ROOT_W-1];
`else
  assign w_man_out     = r_root[MAN_W-1:0];
  assign w_exp_out     = r_exp;
  assign w_unused_bits = &{1'b0, r_root[ROOT_W-1:MAN_W]};
`endif

  logic w_unused_sign;
  assign w_unused_sign = &{1'b0, A[31], w_unused_bits};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = w_special ? ST_FIN : ST_ITER;
      ST_ITER: if (r_cnt == CNT_W'(LAST_CNT)) w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = start ? (w_special ? ST_FIN : ST_ITER) : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_rad     <= '0;
      r_rem     <= '0;
      r_root    <= '0;
      r_exp     <= '0;
      r_special <= 1'b0;
      r_ans     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_ITER) begin
        r_rem  <= w_rem_nx;
        r_root <= {r_root[ROOT_W-2:0], w_ge};
        r_rad  <= {r_rad[RAD_W-3:0], 2'b00};
        r_cnt  <= r_cnt + 1'b1;
      end
      if (r_state == ST_FIN) begin
        r_ans  <= r_special ? 32'h0 : {1'b0, w_exp_out, w_man_out};
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
      if (w_accept) begin
        r_special <= w_special;
        r_rad     <= w_rad_init;
        r_exp     <= w_exp_sum[EXP_W:1];
        r_rem     <= '0;
        r_root    <= '0;
        r_cnt     <= '0;
        r_busy    <= 1'b1;
      end
    end
  end

  assign ansS = r_ans;
  assign busy = r_busy;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_iter_core.sv
// ============================================================================
// tb_sqrt_iter_core : directed vectors with a queue scoreboard and monitor.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sqrt_iter_core;

`ifdef SQRT_ROUND_NEAREST_EN
  localparam int LAT = 26;
  localparam logic [31:0] EXP_FIVE = 32'h400F1BBD;
`else
  localparam int LAT = 25;
  localparam logic [31:0] EXP_FIVE = 32'h400F1BBC;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] ansS;
  logic        busy;
  logic        done;

  sqrt_iter_core #(.ITER_BITS(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .ansS  (ansS),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(posedge clk) begin
    #1;
    if (rst_n && done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_ansS"}, ansS, e.val);
        chk({e.name, "_latency"}, 32'(cyc - e.cyc), 32'(e.lat));
      end
    end
  end

  // Called at a negedge; the next posedge is the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] exp_v, input int lat, input string nm);
    exp_t e;
    start = 1'b1;
    A     = a;
    e.val = exp_v; e.cyc = cyc + 1; e.lat = lat; e.name = nm;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int  k = 0;
    bit  low_seen = 1'b0;
    while (!done && k < 60) begin
      if (!busy) low_seen = 1'b1;
      @(negedge clk);
      k++;
    end
    if (k >= 60) begin
      chk({nm, "_timeout"}, 32'd1, 32'd0);
    end else begin
      chk({nm, "_busy_gap"}, 32'(low_seen), 32'd0);
      chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int done_before;
    repeat (3) @(negedge clk);
    chk("reset_ansS", ansS, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h40800000, 32'h40000000, LAT, "sqrt4");
    chk("sqrt4_busy_after_accept", 32'(busy), 32'd1);
    wait_done("sqrt4");
    repeat (5) @(negedge clk);
    chk("hold_ansS", ansS, 32'h40000000);

    issue(32'h41100000, 32'h40400000, LAT, "sqrt9");    wait_done("sqrt9");
    issue(32'h3F800000, 32'h3F800000, LAT, "sqrt1");    wait_done("sqrt1");
    issue(32'h40A00000, EXP_FIVE,     LAT, "sqrt5");    wait_done("sqrt5");
    issue(32'hC0800000, 32'h40000000, LAT, "neg4");     wait_done("neg4");
    issue(32'h00000000, 32'h00000000, 1,   "zero");     wait_done("zero");
    issue(32'h7F800000, 32'h00000000, 1,   "inf");      wait_done("inf");
    issue(32'h7FC00000, 32'h00000000, 1,   "nan");      wait_done("nan");
    issue(32'h00000001, 32'h00000000, 1,   "denorm");   wait_done("denorm");

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(32'h40800000, 32'h40000000, LAT, "busy4");
    repeat (8) @(negedge clk);
    start = 1'b1; A = 32'h41100000;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy4");
    issue(32'h41100000, 32'h40400000, LAT, "b2b9");
    wait_done("b2b9");

    // Reset mid-iteration aborts with no done.
    issue(32'h41100000, 32'h40400000, LAT, "abort9");
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb_q.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ansS", ansS, 32'h0);
    rst_n = 1'b1;
    done_before = n_done;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(n_done - done_before), 32'd0);

    issue(32'h40800000, 32'h40000000, LAT, "recover4");
    wait_done("recover4");
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
